// File: rtl/hazard_forward_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage pipeline.
// Optional stall counter enabled by defining HAZARD_STALL_COUNT_EN.

module hazard_fwd_lane #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  srcValid,
  input  logic                  exRegWrite,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exWriteReg,
  input  logic                  memRegWrite,
  input  logic [REG_ADDR_W-1:0] memWriteReg,
  output logic [SEL_W-1:0]      nextSel,
  output logic                  loadHit
);
  logic exHit, memHit;

  // $0 is hardwired; it never has a producer worth forwarding.
  assign exHit  = srcValid && (src != '0) && exRegWrite  && (exWriteReg  == src);
  assign memHit = srcValid && (src != '0) && memRegWrite && (memWriteReg == src);

  // Youngest producer wins; WB producers are served by the register file.
  assign nextSel = exHit ? SEL_W'(1) : (memHit ? SEL_W'(2) : '0);
  assign loadHit = exHit && exMemRead;
endmodule

module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] IfId_Rs,
  input  logic [REG_ADDR_W-1:0] IfId_Rt,
  input  logic                  IfId_UsesRt,
  input  logic                  Id_RegWrite,
  input  logic                  Id_MemRead,
  input  logic [REG_ADDR_W-1:0] Id_WriteReg,
  input  logic                  Flush,
`ifdef HAZARD_STALL_COUNT_EN
  output logic [15:0]           StallCount,
`endif
  output logic [SEL_W-1:0]      FwdSelA,
  output logic [SEL_W-1:0]      FwdSelB,
  output logic                  Stall
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic                  regWrite;
    logic                  memRead;
    logic [REG_ADDR_W-1:0] writeReg;
  } exShadowT;

  // Nothing downstream of MEM needs MemRead, and a WB producer never
  // changes a select, so the later shadow stages keep only what matters.
  typedef struct packed {
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeReg;
  } memShadowT;

  exShadowT  exSh;
  memShadowT memSh;

  logic [NUM_LANES-1:0][REG_ADDR_W-1:0] laneSrc;
  logic [NUM_LANES-1:0]                 laneValid;
  logic [NUM_LANES-1:0][SEL_W-1:0]      laneSel;
  logic [NUM_LANES-1:0]                 laneLoadHit;
  logic [NUM_LANES-1:0][SEL_W-1:0]      fwdSel;
  logic                                 bubble;

  assign laneSrc   = {IfId_Rt, IfId_Rs};
  assign laneValid = {IfId_UsesRt, 1'b1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    hazard_fwd_lane #(.REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) uLane (
      .src        (laneSrc[g]),
      .srcValid   (laneValid[g]),
      .exRegWrite (exSh.regWrite),
      .exMemRead  (exSh.memRead),
      .exWriteReg (exSh.writeReg),
      .memRegWrite(memSh.regWrite),
      .memWriteReg(memSh.writeReg),
      .nextSel    (laneSel[g]),
      .loadHit    (laneLoadHit[g])
    );
  end

  // A squashed ID instruction can't create a hazard, so Flush masks Stall.
  assign Stall  = (|laneLoadHit) && !Flush;
  assign bubble = Stall || Flush;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      exSh   <= '0;
      memSh  <= '0;
      fwdSel <= '0;
    end else begin
      memSh  <= '{regWrite: exSh.regWrite, writeReg: exSh.writeReg};
      exSh   <= bubble ? '0 : '{regWrite: Id_RegWrite, memRead: Id_MemRead,
                                writeReg: Id_WriteReg};
      fwdSel <= bubble ? '0 : laneSel;
    end
  end

  assign FwdSelA = fwdSel[0];
  assign FwdSelB = fwdSel[1];

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset)
      StallCount <= '0;
    else if (Stall && (StallCount != 16'hFFFF))
      StallCount <= StallCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed vector table,
// a reset-mid-stall sequence, and randomized traffic against a reference model.

module tb_hazard_forward_ctrl;
  logic       Clk, Reset, IfId_UsesRt, Id_RegWrite, Id_MemRead, Flush, Stall;
  logic [4:0] IfId_Rs, IfId_Rt, Id_WriteReg;
  logic [2:0] FwdSelA, FwdSelB;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .SEL_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
    .IfId_UsesRt(IfId_UsesRt), .Id_RegWrite(Id_RegWrite), .Id_MemRead(Id_MemRead),
    .Id_WriteReg(Id_WriteReg), .Flush(Flush),
`ifdef HAZARD_STALL_COUNT_EN
    .StallCount(StallCount),
`endif
    .FwdSelA(FwdSelA), .FwdSelB(FwdSelB), .Stall(Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit       rst, flush, uses, rw, mr;
    bit [4:0] rs, rt, wd;
    bit       chkStall, expStall;
    bit [2:0] expA, expB;
  } vecT;

  // An instruction that has been let into EX; the empty one is a bubble.
  typedef struct { bit rw, mr; bit [4:0] wd; } instT;

  vecT  vec[$];
  instT inflight[$];  // [0] = EX, [1] = MEM
  int   modelCnt;

  function automatic vecT mk(bit rst, bit flush, bit [4:0] rs, bit [4:0] rt, bit uses,
                             bit rw, bit mr, bit [4:0] wd, bit chkS, bit expS,
                             bit [2:0] eA, bit [2:0] eB);
    vecT v;
    v.rst = rst; v.flush = flush; v.rs = rs; v.rt = rt; v.uses = uses;
    v.rw = rw; v.mr = mr; v.wd = wd; v.chkStall = chkS; v.expStall = expS;
    v.expA = eA; v.expB = eB;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vecT v);
    Reset = v.rst; Flush = v.flush; IfId_Rs = v.rs; IfId_Rt = v.rt;
    IfId_UsesRt = v.uses; Id_RegWrite = v.rw; Id_MemRead = v.mr; Id_WriteReg = v.wd;
  endtask

  // One cycle: inputs already sit just after an edge; Stall is sampled at
  // the falling edge, the registered selects just after the next rising edge.
  task automatic runVec(input string tag, input vecT v);
    drive(v);
    @(negedge Clk);
    if (v.chkStall) chk({tag, ".Stall"}, int'(Stall), int'(v.expStall));
    @(posedge Clk); #1;
    chk({tag, ".FwdSelA"}, int'(FwdSelA), int'(v.expA));
    chk({tag, ".FwdSelB"}, int'(FwdSelB), int'(v.expB));
  endtask

  // Reference: the most recent in-flight writer of a source decides its select.
  function automatic int refSel(bit [4:0] s);
    if (s == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (inflight[i].rw && inflight[i].wd == s) return i + 1;
    return 0;
  endfunction

  function automatic bit refStall(vecT v);
    instT p = inflight[0];
    if (v.flush || !(p.rw && p.mr) || p.wd == 0) return 0;
    return (p.wd == v.rs) || (v.uses && p.wd == v.rt);
  endfunction

  initial begin
    instT empty = '{rw: 0, mr: 0, wd: 0};
    string tag;

    // rst flush rs rt uses rw mr wd | chkS expS A B
    vec.push_back(mk(1,1, 4, 9,1, 1,1, 4, 0,0, 0,0));  // reset, noisy inputs
    vec.push_back(mk(1,0, 4, 4,1, 1,1, 4, 1,0, 0,0));  // 2nd reset cycle
    vec.push_back(mk(0,0, 0, 0,0, 1,0, 3, 1,0, 0,0));  // writer $3
    vec.push_back(mk(0,0, 3, 9,0, 0,0, 0, 1,0, 1,0));  // rs=3 -> EX fwd
    vec.push_back(mk(0,0, 0, 0,0, 1,0, 5, 1,0, 0,0));  // writer $5
    vec.push_back(mk(0,0, 1, 1,1, 0,0, 0, 1,0, 0,0));  // unrelated
    vec.push_back(mk(0,0, 0, 5,1, 0,0, 0, 1,0, 0,2));  // rt=5 -> MEM fwd
    vec.push_back(mk(0,0, 0, 0,0, 1,0, 2, 1,0, 0,0));  // writer $2
    vec.push_back(mk(0,0, 0, 0,0, 1,0, 2, 1,0, 0,0));  // writer $2 again
    vec.push_back(mk(0,0, 2, 0,0, 0,0, 0, 1,0, 1,0));  // younger wins
    vec.push_back(mk(0,0, 0, 0,0, 1,1, 4, 1,0, 0,0));  // lw $4
    vec.push_back(mk(0,0, 4, 0,0, 1,0, 8, 1,1, 0,0));  // add rs=4: stall
    vec.push_back(mk(0,0, 4, 0,0, 1,0, 8, 1,0, 2,0));  // retry: load in MEM
    vec.push_back(mk(0,0, 0, 0,0, 1,1, 0, 1,0, 0,0));  // lw $0
    vec.push_back(mk(0,0, 0, 0,1, 0,0, 0, 1,0, 0,0));  // $0 consumer: no stall
    vec.push_back(mk(0,0, 0, 0,0, 1,1, 7, 1,0, 0,0));  // lw $7
    vec.push_back(mk(0,1, 7, 0,0, 1,0, 9, 1,0, 0,0));  // flushed consumer
    vec.push_back(mk(0,0, 7, 0,0, 0,0, 0, 1,0, 2,0));  // next reader of $7
    vec.push_back(mk(0,0, 0, 0,0, 1,1, 9, 1,0, 0,0));  // lw $9
    vec.push_back(mk(0,0, 9, 0,0, 0,0, 0, 1,1, 0,0));  // stall
    vec.push_back(mk(0,0, 9, 0,0, 0,0, 0, 1,0, 2,0));  // first consumer
    vec.push_back(mk(0,0, 0, 9,1, 0,0, 0, 1,0, 0,0));  // second: no stall
    vec.push_back(mk(0,0, 0, 0,0, 1,0, 6, 1,0, 0,0));  // writer $6
    vec.push_back(mk(0,0, 0, 0,0, 1,1, 6, 1,0, 0,0));  // lw $6
    vec.push_back(mk(0,0, 6, 0,0, 0,0, 0, 1,1, 0,0));  // stall
    vec.push_back(mk(0,0, 6, 0,0, 0,0, 0, 1,0, 2,0));  // load is the source

    drive(vec[0]);
    @(posedge Clk); #1;
    foreach (vec[i]) begin
      tag = $sformatf("vec%0d", i);
      runVec(tag, vec[i]);
`ifdef HAZARD_STALL_COUNT_EN
      if (i == 1) chk("StallCount.reset", int'(StallCount), 0);
`endif
    end
`ifdef HAZARD_STALL_COUNT_EN
    chk("StallCount.table", int'(StallCount), 3);
`endif

    // Reset while a load-use stall is pending: the hazard must not survive.
    runVec("rms.lw",    mk(0,0,  0,0,0, 1,1,10, 1,0, 0,0));
    runVec("rms.stall", mk(0,0, 10,0,0, 0,0, 0, 1,1, 0,0));
    runVec("rms.reset", mk(1,0, 10,0,0, 0,0, 0, 0,0, 0,0));
    runVec("rms.after", mk(0,0, 10,0,0, 0,0, 0, 1,0, 0,0));

    // Random traffic; the first cycle resets so the model starts in step.
    inflight = {empty, empty};
    modelCnt = 0;
    for (int c = 0; c < 600; c++) begin
      vecT  v;
      instT id;
      int   eA, eB;
      bit   st;
      v.rst   = (c == 0) || ($urandom_range(0, 59) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.rs    = 5'($urandom_range(0, 6));
      v.rt    = 5'($urandom_range(0, 6));
      v.uses  = 1'($urandom);
      v.rw    = ($urandom_range(0, 3) != 0);
      v.mr    = ($urandom_range(0, 2) == 0);
      v.wd    = 5'($urandom_range(0, 6));
      drive(v);
      @(negedge Clk);
      if (c != 0) begin
        st = refStall(v);
        chk("rnd.Stall", int'(Stall), int'(st));
      end else st = 0;
      eA = (st || v.flush) ? 0 : refSel(v.rs);
      eB = (st || v.flush || !v.uses) ? 0 : refSel(v.rt);
      if (v.rst) begin
        eA = 0; eB = 0; modelCnt = 0;
        inflight = {empty, empty};
      end else begin
        if (st && modelCnt < 65535) modelCnt++;
        id = '{rw: v.rw, mr: v.mr, wd: v.wd};
        inflight.push_front((st || v.flush) ? empty : id);
        void'(inflight.pop_back());
      end
      @(posedge Clk); #1;
      chk("rnd.FwdSelA", int'(FwdSelA), eA);
      chk("rnd.FwdSelB", int'(FwdSelB), eB);
`ifdef HAZARD_STALL_COUNT_EN
      chk("rnd.StallCount", int'(StallCount), modelCnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
